alu_multicycle: RTL and testbench

//  Registered, parametrised MIPS integer ALU for the execute stage: full R/I-type ALU op set plus

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_muldiv_iter.sv | 132 +++++++++++++
 rtl/alu_multicycle.sv | 184 ++++++++++++++++++
 tb/tb_alu_multicycle.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle MIPS ALU.
//   - MIPS opcode and funct encodings recognised by the decoder
//   - alu_state_t: control FSM states (idle, multiply, divide, completion)
package alu_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} alu_state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative multiplier / restoring divider working on operand magnitudes.
// A start pulse loads the operands; WIDTH steps follow, one per cycle. 'done' is high
// during the cycle in which the last step executes, so hi/lo are final the cycle after.
// Build option: ALU_DIV_EN adds the divider datapath and the is_div port.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           load operands and begin iterating
//   is_signed       treat op1/op2 as two's complement
//   is_div          (ALU_DIV_EN only) divide instead of multiply
//   op1, op2        multiplicand/multiplier or dividend/divisor
//   done            last iteration in progress
//   hi, lo          product {hi,lo}, or remainder/quotient, with sign applied
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
`ifdef ALU_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt_reg;
    logic             active_reg;
    // acc: running high product half / partial remainder; q: multiplier bits / quotient
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] b_reg;
    logic             neg_lo_reg;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod;
`ifdef ALU_DIV_EN
    logic             div_reg;
    logic             dz_reg;
    logic             neg_hi_reg;
    logic [WIDTH-1:0] dividend_reg;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
`endif

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (-v) : v;
    endfunction

    // One iteration step
    always_comb begin
        mul_sum  = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, b_reg} : '0);
        acc_next = mul_sum[WIDTH:1];
        q_next   = {mul_sum[0], q_reg[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_shift = {acc_reg, q_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_reg});
        if (div_reg) begin
            // The true difference is below the divisor, so a WIDTH-bit subtract is exact
            acc_next = div_ge ? (div_shift[WIDTH-1:0] - b_reg) : div_shift[WIDTH-1:0];
            q_next   = {q_reg[WIDTH-2:0], div_ge};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            active_reg   <= 1'b0;
            acc_reg      <= '0;
            q_reg        <= '0;
            b_reg        <= '0;
            neg_lo_reg   <= 1'b0;
`ifdef ALU_DIV_EN
            div_reg      <= 1'b0;
            dz_reg       <= 1'b0;
            neg_hi_reg   <= 1'b0;
            dividend_reg <= '0;
`endif
        end else if (start) begin
            cnt_reg      <= CNT_W'(WIDTH-1);
            active_reg   <= 1'b1;
            acc_reg      <= '0;
            q_reg        <= mag(op1, is_signed);
            b_reg        <= mag(op2, is_signed);
            // Product / quotient is negative when operand signs differ
            neg_lo_reg   <= is_signed && (op1[WIDTH-1] ^ op2[WIDTH-1]);
`ifdef ALU_DIV_EN
            div_reg      <= is_div;
            dz_reg       <= (op2 == '0);
            neg_hi_reg   <= is_signed && op1[WIDTH-1];
            dividend_reg <= op1;
`endif
        end else if (active_reg) begin
            acc_reg <= acc_next;
            q_reg   <= q_next;
            if (cnt_reg == '0) begin
                active_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    end

    assign done = active_reg && (cnt_reg == '0);

    always_comb begin
        prod = {acc_reg, q_reg};
        if (neg_lo_reg) begin
            prod = -prod;
        end
        hi = prod[2*WIDTH-1:WIDTH];
        lo = prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
        if (div_reg) begin
            if (dz_reg) begin
                // Divide by zero reports raw dividend and an all-ones quotient
                hi = dividend_reg;
                lo = '1;
            end else begin
                hi = neg_hi_reg ? (-acc_reg) : acc_reg;
                lo = neg_lo_reg ? (-q_reg) : q_reg;
            end
        end
`endif
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered MIPS execute-stage ALU with iterative MULT/MULTU/DIV/DIVU and HI/LO.
// Single-cycle ops return one cycle after accept; mul/div return WIDTH+1 cycles
// after accept, with in_ready low from accept through the completion cycle.
// Build option: ALU_DIV_EN enables DIV/DIVU; otherwise they complete as illegal.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid, in_ready   request handshake (in_ready = !busy)
//   opcode, func_code    MIPS opcode / funct (funct only for R-type)
//   shamt                shift amount for SLL/SRL/SRA
//   op1, op2             rs value; rt value or extended immediate
//   out_valid            one-cycle completion pulse
//   result, illegal      result value and unsupported-op flag (qualified by out_valid)
//   busy                 mul/div in progress
//   hi, lo               architectural HI/LO
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func_code,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic               illegal,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    import alu_pkg::*;

    alu_state_t       state_reg, state_next;
    logic [WIDTH-1:0] result_reg;
    logic             illegal_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;

    logic [WIDTH-1:0] sc_result;
    logic             dec_illegal, dec_mul, dec_div, dec_signed;
    logic             accept;
    logic             iter_done;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    assign busy     = (state_reg != S_IDLE);
    assign in_ready = !busy;
    assign accept   = in_valid && in_ready;

    // Decode and single-cycle datapath
    always_comb begin
        sc_result   = '0;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        dec_div     = 1'b0;
        dec_signed  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (func_code)
                    FN_SLL:         sc_result = op2 << shamt;
                    FN_SRL:         sc_result = op2 >> shamt;
                    FN_SRA:         sc_result = $signed(op2) >>> shamt;
                    FN_JR, FN_ADDU: sc_result = op1 + op2;
                    FN_SUBU:        sc_result = op1 - op2;
                    FN_AND:         sc_result = op1 & op2;
                    FN_OR:          sc_result = op1 | op2;
                    FN_XOR:         sc_result = op1 ^ op2;
                    FN_NOR:         sc_result = ~(op1 | op2);
                    FN_SLT:         sc_result = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
                    FN_SLTU:        sc_result = {{(WIDTH-1){1'b0}}, op1 < op2};
                    FN_MFHI:        sc_result = hi_reg;
                    FN_MFLO:        sc_result = lo_reg;
                    FN_MULT: begin
                        dec_mul    = 1'b1;
                        dec_signed = 1'b1;
                    end
                    FN_MULTU:       dec_mul = 1'b1;
`ifdef ALU_DIV_EN
                    FN_DIV: begin
                        dec_div    = 1'b1;
                        dec_signed = 1'b1;
                    end
                    FN_DIVU:        dec_div = 1'b1;
`else
                    FN_DIV, FN_DIVU: dec_illegal = 1'b1;
`endif
                    default:        dec_illegal = 1'b1;
                endcase
            end
            OP_ADDIU, OP_LW, OP_SW: sc_result = op1 + op2;
            OP_SLTI:  sc_result = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTIU: sc_result = {{(WIDTH-1){1'b0}}, op1 < op2};
            OP_ANDI:  sc_result = op1 & op2;
            OP_ORI:   sc_result = op1 | op2;
            OP_XORI:  sc_result = op1 ^ op2;
            OP_LUI:   sc_result = op2 << (WIDTH/2);
            default:  dec_illegal = 1'b1;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && (dec_mul || dec_div)),
        .is_signed (dec_signed),
`ifdef ALU_DIV_EN
        .is_div    (dec_div),
`endif
        .op1       (op1),
        .op2       (op2),
        .done      (iter_done),
        .hi        (iter_hi),
        .lo        (iter_lo)
    );

    // Control FSM
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept && dec_mul) begin
                    state_next = S_MUL;
                end else if (accept && dec_div) begin
                    state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (iter_done) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg    <= '0;
            illegal_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            if (accept) begin
                if (dec_mul || dec_div) begin
                    // mul/div completions report result 0
                    result_reg  <= '0;
                    illegal_reg <= 1'b0;
                end else begin
                    result_reg    <= sc_result;
                    illegal_reg   <= dec_illegal;
                    out_valid_reg <= 1'b1;
                end
            end
            if (state_reg == S_DONE) begin
                hi_reg <= iter_hi;
                lo_reg <= iter_lo;
            end
        end
    end

    // The completion cycle of a mul/div is the DONE state itself
    assign out_valid = out_valid_reg || (state_reg == S_DONE);
    assign result    = result_reg;
    assign illegal   = illegal_reg;
    assign hi        = hi_reg;
    assign lo        = lo_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed + randomized bench for alu_multicycle (WIDTH=32), checked against a
// behavioural model using plain 64-bit arithmetic. Follows ALU_DIV_EN like the DUT.
module tb_alu_multicycle;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08;
    localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12, F_MULT = 6'h18, F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV = 6'h1a, F_DIVU = 6'h1b, F_ADDU = 6'h21, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2a, F_SLTU = 6'h2b;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = '0;
    logic [5:0]  func_code = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        out_valid;
    logic [31:0] result;
    logic        illegal;
    logic        busy;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func_code(func_code), .shamt(shamt), .op1(op1), .op2(op2),
        .out_valid(out_valid), .result(result), .illegal(illegal), .busy(busy),
        .hi(hi), .lo(lo)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: result, illegal flag, latency and new HI/LO
    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ill, output int lat,
                         output logic [31:0] nhi, output logic [31:0] nlo);
        longint p;
        int     sa, sb;
        r = '0; ill = 1'b0; lat = 1; nhi = m_hi; nlo = m_lo;
        sa = $signed(a); sb = $signed(b);
        if (op == 6'h00) begin
            case (fn)
                F_SLL:         r = b << sh;
                F_SRL:         r = b >> sh;
                F_SRA:         r = 32'($signed(b) >>> sh);
                F_JR, F_ADDU:  r = a + b;
                F_SUBU:        r = a - b;
                F_AND:         r = a & b;
                F_OR:          r = a | b;
                F_XOR:         r = a ^ b;
                F_NOR:         r = ~(a | b);
                F_SLT:         r = (sa < sb) ? 32'd1 : 32'd0;
                F_SLTU:        r = (a < b) ? 32'd1 : 32'd0;
                F_MFHI:        r = m_hi;
                F_MFLO:        r = m_lo;
                F_MULT: begin
                    lat = 33;
                    p = longint'(sa) * longint'(sb);
                    {nhi, nlo} = p;
                end
                F_MULTU: begin
                    lat = 33;
                    {nhi, nlo} = {32'd0, a} * {32'd0, b};
                end
                F_DIV, F_DIVU: begin
`ifdef ALU_DIV_EN
                    lat = 33;
                    if (b == 0) begin
                        nlo = 32'hFFFF_FFFF; nhi = a;
                    end else if (fn == F_DIVU) begin
                        nlo = a / b; nhi = a % b;
                    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        nlo = 32'h8000_0000; nhi = 32'd0;
                    end else begin
                        nlo = sa / sb; nhi = sa % sb;
                    end
`else
                    ill = 1'b1;
`endif
                end
                default: ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'h09, 6'h23, 6'h2b: r = a + b;
                6'h0a: r = (sa < sb) ? 32'd1 : 32'd0;
                6'h0b: r = (a < b) ? 32'd1 : 32'd0;
                6'h0c: r = a & b;
                6'h0d: r = a | b;
                6'h0e: r = a ^ b;
                6'h0f: r = b << 16;
                default: ill = 1'b1;
            endcase
        end
    endtask

    // Issue one op, wait (bounded) for completion, compare everything against the model
    task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res_o);
        logic [31:0] er, ehi, elo;
        logic        eill;
        int          elat, lat;
        model(op, fn, sh, a, b, er, eill, elat, ehi, elo);
        @(negedge clk);
        opcode = op; func_code = fn; shamt = sh; op1 = a; op2 = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (out_valid) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        res_o = result;
        $display("[TB] %s op=%02h fn=%02h sh=%0d a=%08h b=%08h -> res=%08h ill=%0b lat=%0d",
                 tag, op, fn, sh, a, b, result, illegal, lat);
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " result"}, {32'd0, result}, {32'd0, er});
        check({tag, " illegal"}, {63'd0, illegal}, {63'd0, eill});
        @(negedge clk);
        check({tag, " hilo"}, {hi, lo}, {ehi, elo});
        check({tag, " pulse"}, {63'd0, out_valid}, 64'd0);
        m_hi = ehi;
        m_lo = elo;
    endtask

    logic [11:0] ops_tbl [24] = '{
        {6'h00, F_SLL}, {6'h00, F_SRL}, {6'h00, F_SRA}, {6'h00, F_ADDU},
        {6'h00, F_SUBU}, {6'h00, F_AND}, {6'h00, F_OR}, {6'h00, F_XOR},
        {6'h00, F_NOR}, {6'h00, F_SLT}, {6'h00, F_SLTU}, {6'h00, F_MFHI},
        {6'h00, F_MFLO}, {6'h00, F_MULT}, {6'h00, F_MULTU}, {6'h00, F_DIV},
        {6'h00, F_DIVU}, {6'h09, 6'h00}, {6'h0a, 6'h00}, {6'h0b, 6'h00},
        {6'h0c, 6'h00}, {6'h0f, 6'h00}, {6'h23, 6'h00}, {6'h00, F_JR}
    };

    initial begin
        logic [31:0] r;
        int          busy_cnt;
        int          ov_cnt;
        logic [11:0] enc;
        logic [31:0] a, b;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset ctl", {60'd0, out_valid, illegal, busy, in_ready}, 64'b0001);
        check("reset result", {32'd0, result}, 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;

        // Single-cycle ops
        run_op("addu_wrap", 6'h00, F_ADDU, 5'd0, 32'hFFFF_FFFF, 32'd1, r);
        check("addu_wrap lit", {32'd0, r}, 64'd0);
        run_op("addiu", 6'h09, 6'h00, 5'd0, 32'd5, 32'hFFFF_FFFD, r);
        check("addiu lit", {32'd0, r}, 64'd2);
        run_op("slt", 6'h00, F_SLT, 5'd0, 32'hFFFF_FFFF, 32'd1, r);
        check("slt lit", {32'd0, r}, 64'd1);
        run_op("sltu", 6'h00, F_SLTU, 5'd0, 32'hFFFF_FFFF, 32'd1, r);
        check("sltu lit", {32'd0, r}, 64'd0);
        run_op("sra", 6'h00, F_SRA, 5'd4, 32'd0, 32'h8000_0000, r);
        check("sra lit", {32'd0, r}, 64'hF800_0000);
        run_op("lui", 6'h0f, 6'h00, 5'd0, 32'd0, 32'h0000_1234, r);
        check("lui lit", {32'd0, r}, 64'h1234_0000);
        run_op("illegal_fn", 6'h00, 6'h3f, 5'd0, 32'h55, 32'hAA, r);
        check("illegal_fn lit", {32'd0, r}, 64'd0);

        // MULT -3*7 with cycle-accurate busy/out_valid tracking and an ignored request
        @(negedge clk);
        opcode = 6'h00; func_code = F_MULT; op1 = 32'hFFFF_FFFD; op2 = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        busy_cnt = 0;
        ov_cnt   = 0;
        for (int c = 1; c <= 32; c++) begin
            busy_cnt += int'(busy);
            ov_cnt   += int'(out_valid);
            if (c == 5) begin
                func_code = F_ADDU; op1 = 32'd1; op2 = 32'd1; in_valid = 1'b1;
            end
            if (c == 6) in_valid = 1'b0;
            @(negedge clk);
        end
        $display("[TB] mult -3*7 busy_cycles=%0d early_valid=%0d done_valid=%0b", busy_cnt, ov_cnt, out_valid);
        check("mult busy cycles", 64'(busy_cnt), 64'd32);
        check("mult early valid", 64'(ov_cnt), 64'd0);
        check("mult done valid", {63'd0, out_valid}, 64'd1);
        check("mult done ready", {63'd0, in_ready}, 64'd0);
        check("mult done result", {31'd0, illegal, result}, 64'd0);
        @(negedge clk);
        check("mult hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mult pulse", {62'd0, out_valid, busy}, 64'd0);
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFEB;
        run_op("mflo", 6'h00, F_MFLO, 5'd0, 32'd0, 32'd0, r);
        check("mflo lit", {32'd0, r}, 64'hFFFF_FFEB);

        // Division
        run_op("div_neg", 6'h00, F_DIV, 5'd0, 32'hFFFF_FFF9, 32'd2, r);
`ifdef ALU_DIV_EN
        check("div_neg lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
        check("div_neg kept", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
`endif
        run_op("divu_zero", 6'h00, F_DIVU, 5'd0, 32'd7, 32'd0, r);
`ifdef ALU_DIV_EN
        check("divu_zero lit", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
`else
        check("divu_zero kept", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
`endif
        run_op("div_ovf", 6'h00, F_DIV, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, r);
        run_op("div_zero_s", 6'h00, F_DIV, 5'd0, 32'hFFFF_FF00, 32'd0, r);

        // Reset in the middle of MULTU
        @(negedge clk);
        opcode = 6'h00; func_code = F_MULTU; op1 = 32'h1234_5678; op2 = 32'h9ABC_DEF0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        $display("[TB] reset_mid busy=%0b ready=%0b hi=%08h lo=%08h ov=%0b", busy, in_ready, hi, lo, out_valid);
        check("rst_mid ctl", {61'd0, busy, in_ready, out_valid}, 64'b010);
        check("rst_mid hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        ov_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            ov_cnt += int'(out_valid);
        end
        check("rst_mid no valid", 64'(ov_cnt), 64'd0);
        m_hi = '0;
        m_lo = '0;

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                enc = 12'($urandom);
            end else begin
                enc = ops_tbl[$urandom_range(0, 23)];
            end
            case ($urandom_range(0, 3))
                0:       begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
                1:       begin a = $urandom; b = $urandom_range(0, 3); end
                2:       begin a = 32'h8000_0000; b = $urandom; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op($sformatf("rnd%0d", i), enc[11:6], enc[5:0], 5'($urandom), a, b, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
